// File: rtl/sha2_core.sv
`default_nettype none
// sha2_core: SHA-256 / SHA-224 compression engine, 1, 2 or 4 rounds per clock.
// Blocks arrive pre-padded; W+K for the next round group is prefetched one cycle ahead.
module sha2_core #(
    parameter int BlockWidth     = 512,
    parameter int DigestWidth    = 256,
    parameter int RoundsPerCycle = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [BlockWidth-1:0]  block_i,
    input  logic                   block_valid_i,
    output logic                   block_ready_o,
    input  logic                   last_i,
    input  logic                   mode_i,
    input  logic                   enable_hash_i,
    input  logic                   rst_hash_i,
    output logic                   idle_o,
    output logic                   busy_o,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   digest_valid_o
);

    generate
        if (BlockWidth != 512) begin : g_bad_block_width
            $error("sha2_core: BlockWidth must be 512");
        end
        if (DigestWidth != 256) begin : g_bad_digest_width
            $error("sha2_core: DigestWidth must be 256");
        end
        if (RoundsPerCycle != 1 && RoundsPerCycle != 2 && RoundsPerCycle != 4) begin : g_bad_rounds
            $error("sha2_core: RoundsPerCycle must be 1, 2 or 4");
        end
    endgenerate

    typedef logic [31:0]       word_t;
    typedef logic [7:0][31:0]  regs_t;   // element 0 = a / H0 ... element 7 = h / H7
    typedef logic [15:0][31:0] win_t;    // element 0 = oldest word of the schedule window

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HASHING = 3'd1,
        ST_FINAL   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam regs_t IV256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                               32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam regs_t IV224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                               32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

    localparam word_t K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [6:0] LAST_PREFETCH = 7'd64;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic regs_t round_f(input regs_t s, input word_t wk);
        word_t t1, t2;
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
                  + ((s[4] & s[5]) ^ (~s[4] & s[6])) + wk;
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        return {s[6:4], s[3] + t1, s[2:0], t1 + t2};
    endfunction

    function automatic win_t shift_f(input win_t w);
        word_t nw;
        nw = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
           + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        return {nw, w[15:1]};
    endfunction

    function automatic win_t load_f(input logic [BlockWidth-1:0] blk);
        win_t w;
        for (int k = 0; k < 16; k++) begin
            w[k] = blk[511 - 32*k -: 32];
        end
        return w;
    endfunction

    state_t state, state_next;
    regs_t  v, h, hsum;
    win_t   win;
    logic [RoundsPerCycle-1:0][31:0] wk, wk_next;
    logic [6:0] t;          // index of the next schedule word to prefetch
    logic       primed;     // wk holds the group for the next rounds
    logic       mode;
    logic       last;
    logic [DigestWidth-1:0] digest;

    regs_t rv [RoundsPerCycle+1];
    win_t  rw [RoundsPerCycle+1];

    always_comb begin
        rv[0] = v;
        rw[0] = win;
        for (int j = 0; j < RoundsPerCycle; j++) begin
            rv[j+1]    = round_f(rv[j], wk[j]);
            wk_next[j] = rw[j][0] + K_ROM[6'(32'(t) + j)];
            rw[j+1]    = shift_f(rw[j]);
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            hsum[k] = h[k] + v[k];
        end
    end

    assign block_ready_o  = (state == ST_IDLE || state == ST_WAIT) && !rst_hash_i;
    assign idle_o         = (state == ST_IDLE);
    assign busy_o         = (state == ST_HASHING || state == ST_FINAL);
    assign digest_valid_o = (state == ST_DONE);
    assign digest_o       = digest;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (rst_hash_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (block_valid_i) state_next = ST_HASHING;
                ST_HASHING: if (enable_hash_i && primed && t == LAST_PREFETCH) state_next = ST_FINAL;
                ST_FINAL:   state_next = last ? ST_DONE : ST_WAIT;
                ST_WAIT:    if (block_valid_i) state_next = ST_HASHING;
                ST_DONE:    state_next = ST_DONE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v      <= IV256;
            h      <= IV256;
            win    <= '0;
            wk     <= '0;
            t      <= '0;
            primed <= 1'b0;
            mode   <= 1'b0;
            last   <= 1'b0;
            digest <= '0;
        end else if (rst_hash_i) begin
            v      <= IV256;
            h      <= IV256;
            win    <= '0;
            wk     <= '0;
            t      <= '0;
            primed <= 1'b0;
            mode   <= 1'b0;
            last   <= 1'b0;
            digest <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (block_valid_i) begin
                        mode   <= mode_i;
                        v      <= mode_i ? IV224 : IV256;
                        h      <= mode_i ? IV224 : IV256;
                        win    <= load_f(block_i);
                        last   <= last_i;
                        t      <= '0;
                        primed <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (block_valid_i) begin
                        win    <= load_f(block_i);
                        last   <= last_i;
                        t      <= '0;
                        primed <= 1'b0;
                    end
                end
                ST_HASHING: begin
                    // First enabled cycle only fills wk; rounds start once primed.
                    if (enable_hash_i) begin
                        wk     <= wk_next;
                        win    <= rw[RoundsPerCycle];
                        t      <= t + 7'(RoundsPerCycle);
                        primed <= 1'b1;
                        if (primed) begin
                            v <= rv[RoundsPerCycle];
                        end
                    end
                end
                ST_FINAL: begin
                    h <= hsum;
                    if (last) begin
                        if (mode) begin
                            digest <= {hsum[0], hsum[1], hsum[2], hsum[3],
                                       hsum[4], hsum[5], hsum[6], 32'h0};
                        end else begin
                            digest <= {hsum[0], hsum[1], hsum[2], hsum[3],
                                       hsum[4], hsum[5], hsum[6], hsum[7]};
                        end
                    end else begin
                        v <= hsum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha2_core.sv
`default_nettype none
// tb_sha2_core: runs RoundsPerCycle = 1, 2, 4 side by side against a reference SHA-2 model.
module tb_sha2_core;
    localparam int N = 3;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [511:0]  block;
    logic [N-1:0]  valid;
    logic          last, mode, en, rst_hash;
    logic [N-1:0]  ready, idle, busy, dvalid;
    logic [255:0]  digest [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sha2_core #(.BlockWidth(512), .DigestWidth(256), .RoundsPerCycle(1 << g)) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .block_i(block), .block_valid_i(valid[g]),
            .block_ready_o(ready[g]), .last_i(last), .mode_i(mode), .enable_hash_i(en),
            .rst_hash_i(rst_hash), .idle_o(idle[g]), .busy_o(busy[g]),
            .digest_o(digest[g]), .digest_valid_o(dvalid[g]));
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc [N];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-2: full 64-word schedule, one round per loop iteration.
    function automatic logic [255:0] sha_blocks(input logic [511:0] blks [8], input int n, input bit md);
        logic [31:0] hh [8];
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int k = 0; k < 8; k++) hh[k] = md ? IV224[k] : IV256[k];
        for (int bi = 0; bi < n; bi++) begin
            for (int k = 0; k < 16; k++) w[k] = blks[bi][511 - 32*k -: 32];
            for (int k = 16; k < 64; k++)
                w[k] = (rotr(w[k-2], 17) ^ rotr(w[k-2], 19) ^ (w[k-2] >> 10)) + w[k-7]
                     + (rotr(w[k-15], 7) ^ rotr(w[k-15], 18) ^ (w[k-15] >> 3)) + w[k-16];
            a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
            e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
            for (int k = 0; k < 64; k++) begin
                t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[k] + w[k];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
            hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
        end
        if (md) return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], 32'h0};
        return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    endfunction

    // Transaction-level model: phase plus a count of cycles left before the digest is due.
    typedef enum {P_IDLE, P_BUSY, P_WAIT, P_DONE} phase_t;
    phase_t       ph    [N];
    int           left  [N];
    int           nb    [N];
    bit           m_last[N];
    bit           m_mode[N];
    logic [511:0] mb    [N][8];
    logic [255:0] m_dig [N];

    function automatic logic [255:0] model_digest(input int i);
        logic [511:0] tmp [8];
        for (int k = 0; k < 8; k++) tmp[k] = mb[i][k];
        return sha_blocks(tmp, nb[i], m_mode[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ph[i] <= P_IDLE; left[i] <= 0; nb[i] <= 0; m_dig[i] <= '0;
                m_last[i] <= 1'b0; m_mode[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rst_hash) begin
                    ph[i] <= P_IDLE; nb[i] <= 0; m_dig[i] <= '0;
                end else begin
                    case (ph[i])
                        P_IDLE, P_WAIT: if (valid[i]) begin
                            if (ph[i] == P_IDLE) begin
                                m_mode[i] <= mode;
                                mb[i][0]  <= block;
                                nb[i]     <= 1;
                            end else if (nb[i] < 8) begin
                                mb[i][nb[i]] <= block;
                                nb[i]        <= nb[i] + 1;
                            end
                            m_last[i] <= last;
                            left[i]   <= 64 / (1 << i) + 2;
                            ph[i]     <= P_BUSY;
                        end
                        P_BUSY: begin
                            if (left[i] == 1) begin
                                if (m_last[i]) begin
                                    m_dig[i] <= model_digest(i);
                                    ph[i]    <= P_DONE;
                                end else begin
                                    ph[i] <= P_WAIT;
                                end
                            end else if (en) begin
                                left[i] <= left[i] - 1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("ready%0d", i), ready[i], (ph[i] == P_IDLE || ph[i] == P_WAIT) && !rst_hash);
                chk($sformatf("idle%0d", i), idle[i], ph[i] == P_IDLE);
                chk($sformatf("busy%0d", i), busy[i], ph[i] == P_BUSY);
                chk($sformatf("dvalid%0d", i), dvalid[i], ph[i] == P_DONE);
                chk($sformatf("digest%0d", i), digest[i], m_dig[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] b, input bit l, input bit md);
        logic [N-1:0] acc;
        block = b; last = l; mode = md; valid = '1;
        for (int k = 0; k < 300 && valid != '0; k++) begin
            @(negedge clk);
            acc = valid & ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    valid[i]   = 1'b0;
                    acc_cyc[i] = cyc;
                end
            end
        end
        if (valid != '0) begin
            chk("accept_timeout", {253'h0, valid}, 256'h0);
            valid = '0;
        end
    endtask

    task automatic wait_done(input bit rnd, output int lat [N]);
        bit seen [N];
        int nseen = 0;
        for (int i = 0; i < N; i++) begin seen[i] = 1'b0; lat[i] = -1; end
        for (int k = 0; k < 400 && nseen < N; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (dvalid[i] && !seen[i]) begin
                    seen[i] = 1'b1; nseen++; lat[i] = cyc - acc_cyc[i];
                end
            end
            tick();
            if (rnd) en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;
        for (int i = 0; i < N; i++) chk($sformatf("done_seen%0d", i), seen[i], 1);
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (busy != '0 && k < 400) begin tick(); k++; end
        chk("wait_block1", {253'h0, busy}, 256'h0);
    endtask

    task automatic abort();
        rst_hash = 1'b1;
        tick();
        rst_hash = 1'b0;
        tick();
    endtask

    int lat [N];
    int exp_lat [N] = '{66, 34, 18};
    logic [511:0] pv [8];

    initial begin
        block = '0; valid = '0; last = 1'b0; mode = 1'b0; en = 1'b1; rst_hash = 1'b0;
        for (int k = 0; k < 8; k++) pv[k] = '0;

        // Pin the reference model against published digests.
        pv[0] = ABC_BLK;   chk("model_abc256", sha_blocks(pv, 1, 1'b0), D_ABC256);
        chk("model_abc224", sha_blocks(pv, 1, 1'b1), D_ABC224);
        pv[0] = EMPTY_BLK; chk("model_empty", sha_blocks(pv, 1, 1'b0), D_EMPTY);
        pv[0] = TWO_B1; pv[1] = TWO_B2; chk("model_two", sha_blocks(pv, 2, 1'b0), D_TWO);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_ready%0d", i), ready[i], 1);
            chk($sformatf("rst_idle%0d", i), idle[i], 1);
            chk($sformatf("rst_dvalid%0d", i), dvalid[i], 0);
            chk($sformatf("rst_digest%0d", i), digest[i], 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        send(ABC_BLK, 1'b1, 1'b0);
        wait_done(1'b0, lat);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("lat_abc%0d", i), 256'(lat[i]), 256'(exp_lat[i]));
            chk($sformatf("abc256_%0d", i), digest[i], D_ABC256);
        end
        abort();

        send(ABC_BLK, 1'b1, 1'b1);
        wait_done(1'b0, lat);
        for (int i = 0; i < N; i++) chk($sformatf("abc224_%0d", i), digest[i], D_ABC224);
        abort();

        send(TWO_B1, 1'b0, 1'b0);
        wait_not_busy();
        for (int k = 0; k < 6; k++) begin mode = ~mode; tick(); end
        send(TWO_B2, 1'b1, 1'b1);
        wait_done(1'b0, lat);
        for (int i = 0; i < N; i++) chk($sformatf("two_%0d", i), digest[i], D_TWO);
        abort();

        send(EMPTY_BLK, 1'b1, 1'b0);
        wait_done(1'b1, lat);
        for (int i = 0; i < N; i++) chk($sformatf("empty_%0d", i), digest[i], D_EMPTY);
        abort();

        send(TWO_B1, 1'b0, 1'b0);
        repeat (30) tick();
        abort();
        send(ABC_BLK, 1'b1, 1'b0);
        wait_done(1'b0, lat);
        for (int i = 0; i < N; i++) chk($sformatf("abort_abc%0d", i), digest[i], D_ABC256);
        abort();

        send(ABC_BLK, 1'b1, 1'b0);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("arst_ready%0d", i), ready[i], 1);
            chk($sformatf("arst_idle%0d", i), idle[i], 1);
            chk($sformatf("arst_busy%0d", i), busy[i], 0);
            chk($sformatf("arst_dvalid%0d", i), dvalid[i], 0);
            chk($sformatf("arst_digest%0d", i), digest[i], 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
